alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU downstream of alucontrol. Consumes the one-hot `ALU_OP_WIDTH operation vector plus
//  two operands and a writeback tag. Produces a registered result with a valid/ready handshake to the MEM stage.
//  Add/sub/logic/compare complete in one cycle. Shifts run on a 1-bit/cycle serial shifter unless the fast-shift
//  option is compiled in.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width (= `DATA_WIDTH)
//  OP_WIDTH     10  one-hot op vector width (= `ALU_OP_WIDTH); bit positions are `OP_DECINFO_*
//  SHAMT_WIDTH  5   shift amount bits taken from op_b[SHAMT_WIDTH-1:0]
//  TAG_WIDTH    5   rd index carried alongside the operation
// PORTS
//  clk        in   1           core clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  flush      in   1           synchronous kill of in-flight/held operation
//  in_valid   in   1           upstream operation valid
//  in_ready   out  1           unit can accept this cycle
//  alu_op     in   OP_WIDTH    one-hot operation from alucontrol
//  op_a       in   DATA_WIDTH  operand A (rs1/pc)
//  op_b       in   DATA_WIDTH  operand B (rs2/imm)
//  in_tag     in   TAG_WIDTH   destination register index
//  out_valid  out  1           result register holds a valid result
//  out_ready  in   1           downstream consumes result this cycle
//  out_result out  DATA_WIDTH  registered result
//  out_zero   out  1           out_result == 0 (beq/bne decision via SUB)
//  out_err    out  1           alu_op had more than one bit set
//  out_tag    out  TAG_WIDTH   in_tag of the op that produced out_result
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, out_result, out_zero, out_err, out_tag, shift counter all 0; in_ready=1 after reset.
//  in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
//  Ops: ADD a+b, SUB a-b (mod 2^DATA_WIDTH), XOR/OR/AND bitwise, SLT signed a<b -> {0..,1}, SLTU unsigned,
//   SLL/SRL/SRA by op_b[SHAMT_WIDTH-1:0]; SRA replicates op_a MSB.
//  alu_op==0 (e.g. CSR/nop) -> result 0, out_err=0. More than one bit set -> result 0, out_err=1.
//  Latency (accept cycle T, out_valid first high in cycle T+L): non-shift L=1. Shift, shamt=0: L=1.
//   Shift, shamt=N>=1: L=N+1.
//  FSM: IDLE -accept shift, shamt!=0-> SHIFT (load work=op_a, cnt=shamt, latch kind+tag).
//   SHIFT: each cycle shift work 1 bit, cnt-=1; when cnt==1, write output register, go to IDLE.
//   Any other accept writes the output register directly and stays in IDLE.
//  Output register: holds while out_valid && !out_ready. Drain and new accept can happen in the same cycle;
//   back-to-back 1-cycle ops sustain 1 op/cycle.
//  out_valid clears on the out_ready edge unless new data is written that edge.
//  flush: at the next edge state->IDLE, out_valid->0, cnt->0. No accept in a flush cycle. A completing shift
//   in the flush cycle is discarded.
//  out_zero and out_err are registered with out_result.
// CONFIGURATION
//  ALU_EX_FAST_SHIFT_EN defined: single-cycle barrel shifter; SHIFT state unused, all ops L=1, in_ready never
//   drops for shifts.
//  Undefined: serial shifter as above (area-reduced build).
// TESTING
//  Reset mid-SHIFT (SLL shamt=20, rst_n low at cycle 5) -> all outputs 0 immediately, in_ready=1 after release.
//  ADD a=0xFFFFFFFF b=1 -> out_result=0, out_zero=1, L=1. SUB a=5 b=7 -> 0xFFFFFFFE. SLT a=0x80000000 b=1 -> 1.
//   SLTU same operands -> 0.
//  SRA a=0x80000000 shamt=31 -> 0xFFFFFFFF, out_valid at T+32, in_ready=0 for 31 cycles (serial).
//   With ALU_EX_FAST_SHIFT_EN: T+1.
//  out_ready held 0 for 3 cycles after an AND result -> result/tag stable, in_ready=0, no loss. Then 4 back-to-back
//   ADDs -> 1 result per cycle.
//  Flush during SLL shamt=10 at cycle 4 -> out_valid never rises for it. Next ADD 2+3 -> 5 at L=1.
//  alu_op=0 -> result 0, err=0. alu_op with ADD|XOR set -> result 0, out_err=1, tag passed through.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-hot op decode, registered result with valid/ready handshake to MEM.
// Build option ALU_EX_FAST_SHIFT_EN selects a single-cycle barrel shifter instead of the 1-bit/cycle serial shifter.
module alu_exec_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OP_WIDTH    = 10,
    parameter int unsigned SHAMT_WIDTH = 5,
    parameter int unsigned TAG_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_err,
    output logic [TAG_WIDTH-1:0]  out_tag
);
    // One-hot bit positions of the operation vector
    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_AND  = 4;
    localparam int unsigned OP_SLT  = 5;
    localparam int unsigned OP_SLTU = 6;
    localparam int unsigned OP_SLL  = 7;
    localparam int unsigned OP_SRL  = 8;
    localparam int unsigned OP_SRA  = 9;

`ifdef ALU_EX_FAST_SHIFT_EN
    localparam bit SerialShift = 1'b0;
`else
    localparam bit SerialShift = 1'b1;
`endif

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_e;

    state_e                  state_q,      state_d;
    shift_e                  kind_q,       kind_d;
    logic [DATA_WIDTH-1:0]   work_q,       work_d;
    logic [SHAMT_WIDTH-1:0]  cnt_q,        cnt_d;
    logic [TAG_WIDTH-1:0]    tag_q,        tag_d;
    logic                    out_valid_q,  out_valid_d;
    logic [DATA_WIDTH-1:0]   out_result_q, out_result_d;
    logic                    out_zero_q,   out_zero_d;
    logic                    out_err_q,    out_err_d;
    logic [TAG_WIDTH-1:0]    out_tag_q,    out_tag_d;

    logic [SHAMT_WIDTH-1:0]  shamt_c;
    logic                    op_multi_c;
    logic                    op_shift_c;
    logic                    start_serial_c;
    logic                    accept_c;
    logic [DATA_WIDTH-1:0]   alu_res_c;
    logic [DATA_WIDTH-1:0]   shift_step_c;

    assign shamt_c        = op_b[SHAMT_WIDTH-1:0];
    assign op_multi_c     = |(alu_op & (alu_op - OP_WIDTH'(1)));
    assign op_shift_c     = !op_multi_c && (alu_op[OP_SLL] || alu_op[OP_SRL] || alu_op[OP_SRA]);
    assign start_serial_c = SerialShift && op_shift_c && (shamt_c != '0);
    assign in_ready       = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
    assign accept_c       = in_valid && in_ready;

    // Single-cycle result; illegal multi-hot and empty op vectors both yield zero
    always_comb begin
        alu_res_c = '0;
        if (!op_multi_c) begin
            if (alu_op[OP_ADD])  alu_res_c = op_a + op_b;
            if (alu_op[OP_SUB])  alu_res_c = op_a - op_b;
            if (alu_op[OP_XOR])  alu_res_c = op_a ^ op_b;
            if (alu_op[OP_OR])   alu_res_c = op_a | op_b;
            if (alu_op[OP_AND])  alu_res_c = op_a & op_b;
            if (alu_op[OP_SLT])  alu_res_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            if (alu_op[OP_SLTU]) alu_res_c = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_EX_FAST_SHIFT_EN
            if (alu_op[OP_SLL])  alu_res_c = op_a << shamt_c;
            if (alu_op[OP_SRL])  alu_res_c = op_a >> shamt_c;
            if (alu_op[OP_SRA])  alu_res_c = $unsigned($signed(op_a) >>> shamt_c);
`else
            // Serial build only completes zero-amount shifts here
            if (op_shift_c)      alu_res_c = op_a;
`endif
        end
    end

    always_comb begin
        case (kind_q)
            SH_SRL:  shift_step_c = {1'b0, work_q[DATA_WIDTH-1:1]};
            SH_SRA:  shift_step_c = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            default: shift_step_c = {work_q[DATA_WIDTH-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_err_d    = out_err_q;
        out_tag_d    = out_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (start_serial_c) begin
                        state_d = ST_SHIFT;
                        work_d  = op_a;
                        cnt_d   = shamt_c;
                        tag_d   = in_tag;
                        kind_d  = alu_op[OP_SRA] ? SH_SRA : (alu_op[OP_SRL] ? SH_SRL : SH_SLL);
                    end else begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_res_c;
                        out_zero_d   = (alu_res_c == '0);
                        out_err_d    = op_multi_c;
                        out_tag_d    = in_tag;
                    end
                end
            end
            ST_SHIFT: begin
                // Stall the final step if the result register is still occupied
                if (!out_valid_q || out_ready) begin
                    work_d = shift_step_c;
                    cnt_d  = cnt_q - SHAMT_WIDTH'(1);
                    if (cnt_q == SHAMT_WIDTH'(1)) begin
                        state_d      = ST_IDLE;
                        out_valid_d  = 1'b1;
                        out_result_d = shift_step_c;
                        out_zero_d   = (shift_step_c == '0);
                        out_err_d    = 1'b0;
                        out_tag_d    = tag_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            kind_q       <= SH_SLL;
            work_q       <= '0;
            cnt_q        <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_err_q    <= out_err_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_err    = out_err_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reference-model scoreboard plus latency, stall, flush and reset checks.
module tb_alu_exec_unit;
    localparam logic [9:0] OP_ADD  = 10'h001;
    localparam logic [9:0] OP_SUB  = 10'h002;
    localparam logic [9:0] OP_XOR  = 10'h004;
    localparam logic [9:0] OP_OR   = 10'h008;
    localparam logic [9:0] OP_AND  = 10'h010;
    localparam logic [9:0] OP_SLT  = 10'h020;
    localparam logic [9:0] OP_SLTU = 10'h040;
    localparam logic [9:0] OP_SLL  = 10'h080;
    localparam logic [9:0] OP_SRL  = 10'h100;
    localparam logic [9:0] OP_SRA  = 10'h200;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        err;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_err;
    logic [4:0]  out_tag;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    alu_exec_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag);
        exp_t       e;
        logic [4:0] sh;
        sh       = b[4:0];
        e.result = 32'd0;
        e.err    = ($countones(op) > 1);
        e.tag    = tag;
        if (!e.err) begin
            case (op)
                OP_ADD:  e.result = a + b;
                OP_SUB:  e.result = a - b;
                OP_XOR:  e.result = a ^ b;
                OP_OR:   e.result = a | b;
                OP_AND:  e.result = a & b;
                OP_SLT:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                OP_SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
                OP_SLL:  e.result = a << sh;
                OP_SRL:  e.result = a >> sh;
                OP_SRA:  e.result = $signed(a) >>> sh;
                default: e.result = 32'd0;
            endcase
        end
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One clock: push on accept, pop and compare on a result transfer
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (in_valid && in_ready) sb.push_back(model(alu_op, op_a, op_b, in_tag));
        if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_result", 64'(out_result), 64'(e.result));
                check("sb_zero",   64'(out_zero),   64'(e.zero));
                check("sb_err",    64'(out_err),    64'(e.err));
                check("sb_tag",    64'(out_tag),    64'(e.tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        drive(op, a, b, tag);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int k;
        int low;
        int seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; op_a = '0; op_b = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  64'(out_valid),  64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_zero",   64'(out_zero),   64'd0);
        check("rst_err",    64'(out_err),    64'd0);
        check("rst_tag",    64'(out_tag),    64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single-cycle ops, issued back to back
        issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd1);
        check("add_lat",  64'(out_valid),  64'd1);
        check("add_res",  64'(out_result), 64'd0);
        check("add_zero", 64'(out_zero),   64'd1);
        issue(OP_SUB, 32'd5, 32'd7, 5'd2);
        check("sub_res", 64'(out_result), 64'hFFFF_FFFE);
        issue(OP_SLT, 32'h8000_0000, 32'd1, 5'd3);
        check("slt_res", 64'(out_result), 64'd1);
        issue(OP_SLTU, 32'h8000_0000, 32'd1, 5'd4);
        check("sltu_res", 64'(out_result), 64'd0);
        issue(OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5'd5);
        issue(OP_OR,  32'h1200_0034, 32'h0056_7800, 5'd6);
        issue(OP_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 5'd7);
        check("sh0_lat", 64'(out_valid),  64'd1);
        check("sh0_res", 64'(out_result), 64'h1234_5678);
        issue(10'h000, 32'd9, 32'd9, 5'd8);
        check("nop_res", 64'(out_result), 64'd0);
        check("nop_err", 64'(out_err),    64'd0);
        issue(OP_ADD | OP_XOR, 32'd9, 32'd9, 5'd17);
        check("multi_res", 64'(out_result), 64'd0);
        check("multi_err", 64'(out_err),    64'd1);
        check("multi_tag", 64'(out_tag),    64'd17);

        // SRA by 31: latency and in_ready drop
        issue(OP_SRA, 32'h8000_0000, 32'd31, 5'd9);
        k = 0; low = 0;
        while (!out_valid && k < 40) begin
            if (!in_ready) low++;
            tick();
            k++;
        end
        check("sra_valid", 64'(out_valid),  64'd1);
        check("sra_res",   64'(out_result), 64'hFFFF_FFFF);
`ifdef ALU_EX_FAST_SHIFT_EN
        check("sra_lat",   64'(k),   64'd0);
        check("sra_busy",  64'(low), 64'd0);
`else
        check("sra_lat",   64'(k),   64'd31);
        check("sra_busy",  64'(low), 64'd31);
`endif
        issue(OP_SRL, 32'hF000_0001, 32'd3, 5'd10);
        while (!out_valid && k < 80) begin tick(); k++; end
        check("srl_res", 64'(out_result), 64'h1E00_0000);
        tick();

        // Back-pressure: AND result held while an ADD waits upstream
        out_ready = 1'b0;
        issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11);
        drive(OP_ADD, 32'd10, 32'd20, 5'd12);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid",  64'(out_valid),  64'd1);
            check("bp_result", 64'(out_result), 64'hF000_F000);
            check("bp_tag",    64'(out_tag),    64'd11);
            check("bp_ready",  64'(in_ready),   64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_tag", 64'(out_tag),    64'd12);
        check("bp_next_res", 64'(out_result), 64'd30);
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 32'(100 * i), 32'd7, 5'(13 + i));
            tick();
            check("b2b_valid", 64'(out_valid),  64'd1);
            check("b2b_tag",   64'(out_tag),    64'(13 + i));
            check("b2b_res",   64'(out_result), 64'(100 * i + 7));
        end
        in_valid = 1'b0;
        tick();

        // Flush an in-flight SLL by 10
        issue(OP_SLL, 32'd1, 32'd10, 5'd3);
        repeat (3) tick();
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
`ifndef ALU_EX_FAST_SHIFT_EN
        void'(sb.pop_back());
`endif
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
`ifndef ALU_EX_FAST_SHIFT_EN
        check("flush_never_valid", 64'(seen), 64'd0);
`endif
        issue(OP_ADD, 32'd2, 32'd3, 5'd4);
        check("post_flush_lat", 64'(out_valid),  64'd1);
        check("post_flush_res", 64'(out_result), 64'd5);
        tick();

        // Reset in the middle of a long shift
        issue(OP_SLL, 32'd3, 32'd20, 5'd8);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  64'(out_valid),  64'd0);
        check("mid_rst_result", 64'(out_result), 64'd0);
        check("mid_rst_zero",   64'(out_zero),   64'd0);
        check("mid_rst_err",    64'(out_err),    64'd0);
        check("mid_rst_tag",    64'(out_tag),    64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        issue(OP_SUB, 32'd42, 32'd42, 5'd20);
        check("final_zero", 64'(out_zero), 64'd1);
        repeat (2) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
